// File: rtl/wd_pkg.sv
// Shared definitions for the windowed watchdog sequencer.
// Holds the FSM state encoding (also driven on the STATE debug port),
// the interval counter width and the failure counter width.
package wd_pkg;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned FCNT_W  = 8;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_RECOVER = 3'd4
   } wd_state_e;

endpackage

// File: rtl/wd_prescaler.sv
// Watchdog tick prescaler: counts CLK cycles 0..PRESCALE-1 and flags tick
// while the count sits on its last value (so tick is high every cycle when
// PRESCALE=1). clr restarts the count from zero.
// Ports: CLK, RST (sync, active-high), clr (restart), tick (wrap strobe).
module wd_prescaler #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pcnt;
   logic          last;

   assign last = (pcnt == PW'(PRESCALE - 1));
   assign tick = last;

   // Free-running count, restarted on wrap or on request
   always_ff @(posedge CLK) begin
      if (RST || clr || last) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

endmodule

// File: rtl/watchdog_ctrl.sv
// Windowed watchdog sequencer driving the external reset downcounter.
// Times the service interval in prescaled ticks, raises WDFAIL on a late
// kick (or an early kick when windowing is built in), supplies RST_LMT and
// completes the fail/recover handshake through SYS_RSTOUT.
// Build option: define WD_WINDOW_EN for the windowed variant; without it the
// window register is removed and the watchdog is timeout-only.
// Ports: CLK, RST (sync, active-high), EN, KICK, CFG_WE, CFG_TIMEOUT,
//        CFG_WINOPEN, CFG_RSTLMT, SYS_RSTOUT in; WDFAIL, RST_LMT, STATE,
//        FAIL_CNT out (all registered).
module watchdog_ctrl
   import wd_pkg::*;
#(
   parameter int unsigned PRESCALE    = 1000,
   parameter logic [15:0] TIMEOUT_DEF = 16'd5000,
   parameter logic [15:0] WINOPEN_DEF = 16'd0,
   parameter logic [15:0] RSTLMT_DEF  = 16'd100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic        KICK,
   input  logic        CFG_WE,
   input  logic [15:0] CFG_TIMEOUT,
   input  logic [15:0] CFG_WINOPEN,
   input  logic [15:0] CFG_RSTLMT,
   input  logic        SYS_RSTOUT,
   output logic        WDFAIL,
   output logic [15:0] RST_LMT,
   output logic [2:0]  STATE,
   output logic [7:0]  FAIL_CNT
);

   wd_state_e         state, state_next;
   logic              kick_d, kick_e, kick_acc;
   logic              presc_clr, tick;
   logic [CNT_W-1:0]  cnt, timeout_r, rstlmt_r;
   logic [FCNT_W-1:0] fail_cnt;
   logic              wdfail;

   assign kick_e   = KICK & ~kick_d;
   assign WDFAIL   = wdfail;
   assign RST_LMT  = rstlmt_r;
   assign STATE    = state;
   assign FAIL_CNT = fail_cnt;

`ifdef WD_WINDOW_EN
   logic [CNT_W-1:0] win_r, win_eff;
   // A window at or beyond the timeout would never open; treat it as always open
   assign win_eff = (win_r >= timeout_r) ? '0 : win_r;
`else
   logic unused_win;
   assign unused_win = ^{CFG_WINOPEN, WINOPEN_DEF};
`endif

   wd_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (presc_clr),
      .tick (tick)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a kick is tested before the timeout so it wins a tie
   always_comb begin
      state_next = state;
      kick_acc   = 1'b0;
      presc_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (EN) state_next = ST_ARMED;
         end
         ST_ARMED: begin
`ifdef WD_WINDOW_EN
            if (kick_e) begin
               state_next = ST_FAIL;
               kick_acc   = 1'b1;
            end else if (cnt == win_eff) begin
               state_next = ST_OPEN;
            end else if (!EN) begin
               state_next = ST_IDLE;
            end
`else
            if (!EN) state_next = ST_IDLE;
            else     state_next = ST_OPEN;
`endif
         end
         ST_OPEN: begin
            if (kick_e) begin
               state_next = ST_ARMED;
               kick_acc   = 1'b1;
            end else if (cnt >= timeout_r) begin
               state_next = ST_FAIL;
            end else if (!EN) begin
               state_next = ST_IDLE;
            end
         end
         ST_FAIL: begin
            if (SYS_RSTOUT) state_next = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (!SYS_RSTOUT) state_next = EN ? ST_ARMED : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      presc_clr = (state_next != state) || kick_acc;
   end

   // Interval counter, fail flag, fail counter and kick edge register
   always_ff @(posedge CLK) begin
      if (RST) begin
         kick_d   <= 1'b0;
         cnt      <= '0;
         wdfail   <= 1'b0;
         fail_cnt <= '0;
      end else begin
         kick_d <= KICK;
         wdfail <= (state_next == ST_FAIL);
         if (state_next == ST_ARMED && state != ST_ARMED) begin
            cnt <= '0;
         end else if (tick && (state == ST_ARMED || state == ST_OPEN) && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (state_next == ST_FAIL && state != ST_FAIL && fail_cnt != '1) begin
            fail_cnt <= fail_cnt + FCNT_W'(1);
         end
      end
   end

   // Configuration registers, writable only while idle
   always_ff @(posedge CLK) begin
      if (RST) begin
         timeout_r <= (TIMEOUT_DEF == '0) ? CNT_W'(1) : TIMEOUT_DEF;
         rstlmt_r  <= RSTLMT_DEF;
`ifdef WD_WINDOW_EN
         win_r     <= WINOPEN_DEF;
`endif
      end else if (CFG_WE && state == ST_IDLE) begin
         timeout_r <= (CFG_TIMEOUT == '0) ? CNT_W'(1) : CFG_TIMEOUT;
         rstlmt_r  <= CFG_RSTLMT;
`ifdef WD_WINDOW_EN
         win_r     <= CFG_WINOPEN;
`endif
      end
   end

endmodule

// File: doc/watchdog_ctrl.md
Name: watchdog_ctrl

Overview:
- Windowed watchdog sequencer that drives the existing reset downcounter.
- Times the software service interval and asserts WDFAIL on a late kick, or on an early kick when windowing is enabled.
- Supplies the downcounter's RST_LMT and watches its RSTOUT to complete the fail/recover handshake.
- Sits between the CPU-side config/kick interface and the reset-generation path.

Parameters:
- PRESCALE, 1000: CLK cycles per watchdog tick; minimum 1.
- TIMEOUT_DEF, 16'd5000: reset value of the timeout register, in ticks.
- WINOPEN_DEF, 16'd0: reset value of the window-open register, in ticks.
- RSTLMT_DEF, 16'd100: reset value of RST_LMT, in CLK cycles.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- EN  in  1  watchdog enable
- KICK  in  1  service strobe; rising edge detected internally
- CFG_WE  in  1  config write strobe
- CFG_TIMEOUT  in  16  timeout in ticks
- CFG_WINOPEN  in  16  window-open point in ticks
- CFG_RSTLMT  in  16  downcounter limit
- SYS_RSTOUT  in  1  RSTOUT returned from the downcounter
- WDFAIL  out  1  fail request to the downcounter
- RST_LMT  out  16  limit to the downcounter
- STATE  out  3  current FSM state, for debug
- FAIL_CNT  out  8  saturating count of failures

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State returns to IDLE; WDFAIL=0; FAIL_CNT=0; tick and interval counters cleared.
  - Config registers load the *_DEF values, so RST_LMT=RSTLMT_DEF.
  - Reset mid-FAIL drops WDFAIL on the next edge.
- Config:
  - CFG_WE is accepted only in IDLE and ignored in every other state.
  - CFG_TIMEOUT=0 is stored as 1.
  - If win_r >= timeout_r, the window is treated as 0 (always open).
  - RST_LMT is a direct register output.
- Prescaler:
  - Counts 0..PRESCALE-1 and pulses tick on the wrap.
  - Cleared on every state change and on every accepted kick.
  - Interval counter cnt (16-bit) increments on tick and saturates at 16'hFFFF.
- Kick detect: kick_e = KICK & ~KICK_d (one register stage, so one-cycle latency).
- FSM states, encoded on STATE:
  - IDLE (0): EN=1 goes to ARMED with cnt=0.
  - ARMED (1), window closed:
    - kick_e goes to FAIL (early kick).
    - cnt==win_r goes to OPEN.
    - EN=0 goes to IDLE.
  - OPEN (2):
    - kick_e goes to ARMED with cnt cleared.
    - cnt==timeout_r goes to FAIL.
    - EN=0 goes to IDLE.
    - kick_e in the same cycle as cnt reaching timeout_r: the kick wins.
  - FAIL (3):
    - WDFAIL=1, registered and asserted the cycle after entry.
    - FAIL_CNT increments once on entry and saturates at 255.
    - EN is ignored.
    - Stay until SYS_RSTOUT=1, then go to RECOVER.
  - RECOVER (4):
    - WDFAIL=0 so the downcounter clears.
    - Wait for SYS_RSTOUT=0, then go to ARMED if EN=1, else IDLE.
- Kicks outside ARMED/OPEN are ignored.
- WDFAIL is high only in FAIL. There is no path from FAIL to IDLE except through RECOVER or RST.

Optional Feature:
- Macro: WD_WINDOW_EN.
- Defined: windowed behaviour exactly as above.
- Undefined:
  - win_r and CFG_WINOPEN writes are removed.
  - ARMED goes to OPEN on the next cycle with no early-kick check, so the watchdog is timeout-only.
  - STATE encoding is unchanged.

Decomposition:
- Package wd_pkg holds:
  - state encoding constants (IDLE..RECOVER, 3-bit)
  - counter width (16)
  - FAIL_CNT width (8)
- Sub-module wd_prescaler(CLK, RST, clr, tick) with parameter PRESCALE.

Test Plan (PRESCALE=1, TIMEOUT=10, WINOPEN=4, RSTLMT=5, WD_WINDOW_EN defined, downcounter instantiated):
- Timeout: EN=1, no kick. WDFAIL rises 11-12 cycles after ARMED entry. SYS_RSTOUT=1 appears 6 cycles later. RECOVER, then ARMED. FAIL_CNT=1.
- Periodic kicks: kick every 7 ticks. WDFAIL stays 0 for 1000 cycles and STATE toggles between 1 and 2.
- Early kick: kick at cnt=2. FSM goes to FAIL and WDFAIL=1. Same stimulus with WD_WINDOW_EN undefined: no fail.
- Simultaneous events and boundaries:
  - Kick in the same cycle cnt reaches 10: back to ARMED, no fail.
  - CFG_WE while in OPEN: RST_LMT unchanged.
  - CFG_TIMEOUT=0 in IDLE: fail after 1 tick.
- Reset mid-operation: RST asserted while in FAIL gives WDFAIL=0, STATE=0, FAIL_CNT=0 and RST_LMT=100 on the next edge.
- Saturation: force 260 fails; FAIL_CNT holds at 255.
